noc_router_mesh: RTL and testbench

Parametrised five-port wormhole router generalising the fixed 2x2-mesh routers to an arbitrary XY mesh, with configurable data width, input-buffer depth and coordinate width. Each input port (L, N, E, W, S) has a FIFO, XY route computation and packet-lock state. Each output port has a round-robin arbiter and a registered output stage using the existing RTS/CTS/DRTS/DCTS handshake. One instance replaces the per-position noc_router_N variants; ports absent at mesh edges are masked by the Cx connectivity input.

---
 rtl/noc_router_pkg.sv | 50 +++++
 rtl/noc_input_port.sv | 125 ++++++++++++
 rtl/noc_router_mesh.sv | 191 +++++++++++++++++++
 tb/tb_noc_router_mesh.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_router_pkg.sv
// ============================================================================
// Module   : noc_router_pkg
// Purpose  : Shared definitions for the parametrised XY-mesh wormhole router:
//            flit type encodings, port indices, arbiter state encodings and
//            helpers that derive flit field offsets from DATA_WIDTH/COORD_W.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_router_pkg;

    // Flit type field (top three bits of every flit), one-hot
    localparam logic [2:0] c_flit_header = 3'b001;
    localparam logic [2:0] c_flit_body   = 3'b010;
    localparam logic [2:0] c_flit_tail   = 3'b100;

    // Port indices, shared by rx/tx slices, routes and arbiter owners
    localparam logic [2:0] c_port_l = 3'd0;
    localparam logic [2:0] c_port_n = 3'd1;
    localparam logic [2:0] c_port_e = 3'd2;
    localparam logic [2:0] c_port_w = 3'd3;
    localparam logic [2:0] c_port_s = 3'd4;
    localparam int         c_num_ports = 5;

    // Output arbiter states
    localparam logic [0:0] c_arb_idle   = 1'b0;
    localparam logic [0:0] c_arb_locked = 1'b1;

    // Field offsets: type in the top 3 bits, length in the next 12,
    // then {dst_x, dst_y} starting at bit DW-16.
    function automatic int fld_type_msb(input int dw);
        return dw - 1;
    endfunction

    function automatic int fld_dst_x_msb(input int dw);
        return dw - 16;
    endfunction

    function automatic int fld_dst_y_msb(input int dw, input int cw);
        return dw - 16 - cw;
    endfunction

    // Round-robin successor over the five ports (4 wraps to 0)
    function automatic logic [2:0] rr_next(input logic [2:0] p);
        return (p == c_port_s) ? c_port_l : (p + 3'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_input_port.sv
// ============================================================================
// Module   : noc_input_port
// Purpose  : One router input: flit FIFO, XY route computation on the flit at
//            the FIFO head, and (with NOC_PARITY_CHECK_EN) a sticky parity
//            error flag on written flits.
// Ports    : clk, rst (async, active-low)
//            i_cur_x/i_cur_y  router coordinates
//            i_data/i_valid   incoming flit and its valid (drts)
//            o_ready          FIFO not full (cts)
//            i_pop            remove head flit (never asserted when empty)
//            o_head/o_empty   head flit and empty flag
//            o_is_header/o_is_tail/o_route  decoded head type and XY route
//            o_perr           sticky parity error (NOC_PARITY_CHECK_EN only)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_input_port
    import noc_router_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int COORD_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COORD_W-1:0]    i_cur_x,
    input  logic [COORD_W-1:0]    i_cur_y,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic                  o_empty,
    output logic                  o_is_header,
    output logic                  o_is_tail,
    output logic [2:0]            o_route
`ifdef NOC_PARITY_CHECK_EN
    ,
    output logic                  o_perr
`endif
);

    localparam int             c_aw        = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0]  c_full      = (c_aw+1)'(FIFO_DEPTH);
    localparam int             c_type_msb  = fld_type_msb(DATA_WIDTH);
    localparam int             c_dx_msb    = fld_dst_x_msb(DATA_WIDTH);
    localparam int             c_dy_msb    = fld_dst_y_msb(DATA_WIDTH, COORD_W);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]       r_wr_ptr;
    logic [c_aw-1:0]       r_rd_ptr;
    logic [c_aw:0]         r_count;
    logic                  w_push;
    logic [COORD_W-1:0]    w_dst_x;
    logic [COORD_W-1:0]    w_dst_y;

    assign o_ready = (r_count != c_full);
    assign w_push  = i_valid && o_ready;
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // Storage is not reset: the pointers/count alone define what is valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_is_header = (o_head[c_type_msb -: 3] == c_flit_header);
    assign o_is_tail   = (o_head[c_type_msb -: 3] == c_flit_tail);
    assign w_dst_x     = o_head[c_dx_msb -: COORD_W];
    assign w_dst_y     = o_head[c_dy_msb -: COORD_W];

    // Dimension-ordered XY routing: resolve X fully before Y
    always_comb begin
        o_route = c_port_l;
        if (w_dst_x > i_cur_x) begin
            o_route = c_port_e;
        end else if (w_dst_x < i_cur_x) begin
            o_route = c_port_w;
        end else if (w_dst_y > i_cur_y) begin
            o_route = c_port_s;
        end else if (w_dst_y < i_cur_y) begin
            o_route = c_port_n;
        end
    end

`ifdef NOC_PARITY_CHECK_EN
    // Even parity over the whole flit (bit 0 included) must XOR to zero
    logic r_perr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perr <= 1'b0;
        end else if (w_push && (^i_data)) begin
            r_perr <= 1'b1;
        end
    end
    assign o_perr = r_perr;
`endif

endmodule

`default_nettype wire

// File: rtl/noc_router_mesh.sv
// ============================================================================
// Module   : noc_router_mesh
// Purpose  : Five-port (L,N,E,W,S) wormhole router for an arbitrary XY mesh.
//            Per input: FIFO + XY route (noc_input_port). Per output: a
//            round-robin arbiter that locks onto one input from header to
//            tail, and a registered output stage (RTS/CTS/DRTS/DCTS).
// Ports    : clk; rst (async, active-low); cur_x/cur_y router coordinates;
//            Cx {S,W,E,N} output enable mask (L always enabled);
//            rx/drts/cts input side; tx/rts/dcts output side;
//            perr sticky per-input parity error (NOC_PARITY_CHECK_EN only).
// Config   : `define NOC_PARITY_CHECK_EN to add the parity checker and perr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_router_mesh
    import noc_router_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int COORD_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [COORD_W-1:0]      cur_x,
    input  logic [COORD_W-1:0]      cur_y,
    input  logic [3:0]              Cx,
    input  logic [5*DATA_WIDTH-1:0] rx,
    input  logic [4:0]              drts,
    output logic [4:0]              cts,
    output logic [5*DATA_WIDTH-1:0] tx,
    output logic [4:0]              rts,
    input  logic [4:0]              dcts
`ifdef NOC_PARITY_CHECK_EN
    ,
    output logic [4:0]              perr
`endif
);

    logic [DATA_WIDTH-1:0] w_head [c_num_ports];
    logic [4:0]            w_empty;
    logic [4:0]            w_is_hdr;
    logic [4:0]            w_is_tail;
    logic [14:0]           w_route_all;
    logic [4:0]            w_locked;
    logic [4:0]            w_pop;
    logic [4:0]            w_busy;
    logic [4:0]            w_fire;
    logic [14:0]           w_owner_all;
    logic [14:0]           w_src_all;
    logic [4:0]            w_port_en;

    assign w_port_en = {Cx, 1'b1};

    for (genvar gi = 0; gi < c_num_ports; gi++) begin : g_in
        noc_input_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH),
            .COORD_W    (COORD_W)
        ) u_in (
            .clk         (clk),
            .rst         (rst),
            .i_cur_x     (cur_x),
            .i_cur_y     (cur_y),
            .i_data      (rx[gi*DATA_WIDTH +: DATA_WIDTH]),
            .i_valid     (drts[gi]),
            .o_ready     (cts[gi]),
            .i_pop       (w_pop[gi]),
            .o_head      (w_head[gi]),
            .o_empty     (w_empty[gi]),
            .o_is_header (w_is_hdr[gi]),
            .o_is_tail   (w_is_tail[gi]),
            .o_route     (w_route_all[gi*3 +: 3])
`ifdef NOC_PARITY_CHECK_EN
            ,
            .o_perr      (perr[gi])
`endif
        );
    end

    // An input is locked while some arbiter owns it; at most one output can
    // pop a given input because only the owning arbiter reads a locked input
    // and an unlocked header requests exactly one output.
    always_comb begin
        w_locked = '0;
        w_pop    = '0;
        for (int o = 0; o < c_num_ports; o++) begin
            if (w_busy[o]) begin
                w_locked[w_owner_all[o*3 +: 3]] = 1'b1;
            end
            if (w_fire[o]) begin
                w_pop[w_src_all[o*3 +: 3]] = 1'b1;
            end
        end
    end

    for (genvar go = 0; go < c_num_ports; go++) begin : g_out
        logic [0:0]            r_state;
        logic [2:0]            r_owner;
        logic [2:0]            r_last;
        logic [DATA_WIDTH-1:0] r_tx;
        logic                  r_rts;
        logic [0:0]            w_state_nxt;
        logic [2:0]            w_owner_nxt;
        logic [2:0]            w_last_nxt;
        logic                  w_fire_o;
        logic [2:0]            w_src;
        logic [4:0]            w_req;
        logic                  w_found;
        logic [2:0]            w_grant;
        logic [2:0]            w_cand;

        always_comb begin
            for (int i = 0; i < c_num_ports; i++) begin
                w_req[i] = !w_empty[i] && w_is_hdr[i] && !w_locked[i] &&
                           (w_route_all[i*3 +: 3] == 3'(go));
            end
        end

        // Search starts just after the last owner, so priority rotates
        always_comb begin
            w_found = 1'b0;
            w_grant = r_last;
            w_cand  = rr_next(r_last);
            for (int k = 0; k < c_num_ports; k++) begin
                if (!w_found && w_req[w_cand]) begin
                    w_found = 1'b1;
                    w_grant = w_cand;
                end
                w_cand = rr_next(w_cand);
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_owner_nxt = r_owner;
            w_last_nxt  = r_last;
            w_fire_o    = 1'b0;
            w_src       = r_owner;
            case (r_state)
                c_arb_idle: begin
                    // The header is forwarded on the same edge it is granted
                    if (dcts[go] && w_port_en[go] && w_found) begin
                        w_fire_o    = 1'b1;
                        w_src       = w_grant;
                        w_owner_nxt = w_grant;
                        w_state_nxt = c_arb_locked;
                    end
                end
                c_arb_locked: begin
                    if (dcts[go] && !w_empty[r_owner]) begin
                        w_fire_o = 1'b1;
                        if (w_is_tail[r_owner]) begin
                            w_state_nxt = c_arb_idle;
                            w_last_nxt  = r_owner;
                        end
                    end
                end
                default: w_state_nxt = c_arb_idle;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= c_arb_idle;
                r_owner <= c_port_l;
                r_last  <= c_port_s;
                r_tx    <= '0;
                r_rts   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_owner <= w_owner_nxt;
                r_last  <= w_last_nxt;
                r_rts   <= w_fire_o;
                if (w_fire_o) begin
                    r_tx <= w_head[w_src];
                end
            end
        end

        assign w_busy[go]                     = (r_state == c_arb_locked);
        assign w_fire[go]                     = w_fire_o;
        assign w_owner_all[go*3 +: 3]         = r_owner;
        assign w_src_all[go*3 +: 3]           = w_src;
        assign tx[go*DATA_WIDTH +: DATA_WIDTH] = r_tx;
        assign rts[go]                        = r_rts;
    end

endmodule

`default_nettype wire

// File: tb/tb_noc_router_mesh.sv
// ============================================================================
// Module   : tb_noc_router_mesh
// Purpose  : Directed self-checking bench for noc_router_mesh (32-bit flits,
//            depth-4 FIFOs, 2-bit coordinates, router at (1,1)).
// Config   : NOC_PARITY_CHECK_EN enables the parity-error scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_router_mesh;

    localparam int DW = 32;
    localparam int CW = 2;
    localparam int FD = 4;

    localparam logic [2:0] c_hdr  = 3'b001;
    localparam logic [2:0] c_body = 3'b010;
    localparam logic [2:0] c_tail = 3'b100;

    logic            clk = 1'b0;
    logic            rst;
    logic [CW-1:0]   cur_x;
    logic [CW-1:0]   cur_y;
    logic [3:0]      Cx;
    logic [5*DW-1:0] rx;
    logic [4:0]      drts;
    logic [4:0]      cts;
    logic [5*DW-1:0] tx;
    logic [4:0]      rts;
    logic [4:0]      dcts;
`ifdef NOC_PARITY_CHECK_EN
    logic [4:0]      perr;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    noc_router_mesh #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD),
        .COORD_W    (CW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cur_x (cur_x),
        .cur_y (cur_y),
        .Cx    (Cx),
        .rx    (rx),
        .drts  (drts),
        .cts   (cts),
        .tx    (tx),
        .rts   (rts),
        .dcts  (dcts)
`ifdef NOC_PARITY_CHECK_EN
        ,
        .perr  (perr)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {type, len=3, dst_x, dst_y, 12-bit payload, even parity}
    function automatic logic [DW-1:0] mk(input logic [2:0] ty, input logic [1:0] dx,
                                         input logic [1:0] dy, input logic [11:0] pl);
        logic [DW-1:0] f;
        f    = {ty, 12'd3, dx, dy, pl, 1'b0};
        f[0] = ^f[DW-1:1];
        return f;
    endfunction

    function automatic logic [DW-1:0] txs(input int p);
        return tx[p*DW +: DW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int p, input logic [DW-1:0] f);
        rx[p*DW +: DW] = f;
        drts[p]        = 1'b1;
    endtask

    task automatic idle(input int p);
        drts[p] = 1'b0;
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        drts = '0;
        step();
        rst = 1'b1;
        step();
    endtask

    logic [DW-1:0] f0, f1, f2, f3, g0, g1, x;

    initial begin
        rst   = 1'b0;
        cur_x = 2'd1;
        cur_y = 2'd1;
        Cx    = 4'hF;
        rx    = '0;
        drts  = '0;
        dcts  = 5'h1F;
        step();
        step();

        // ---- reset state
        check_eq("reset_cts", 64'(cts), 64'h1F);
        check_eq("reset_rts", 64'(rts), 64'h0);
        check_eq("reset_tx", 64'(tx == '0), 64'h1);
`ifdef NOC_PARITY_CHECK_EN
        check_eq("reset_perr", 64'(perr), 64'h0);
`endif
        rst = 1'b1;
        step();

        // ---- single packet L -> E, 3 flits, latency 2
        f0 = mk(c_hdr, 2'd2, 2'd1, 12'h101);
        f1 = mk(c_body, 2'd2, 2'd1, 12'h102);
        f2 = mk(c_tail, 2'd2, 2'd1, 12'h103);
        put(0, f0); step();
        check_eq("le_lat1_rts", 64'(rts), 64'h0);
        put(0, f1); step();
        check_eq("le_hdr_rts", 64'(rts), 64'b00100);
        check_eq("le_hdr_tx", 64'(txs(2)), 64'(f0));
        put(0, f2); step();
        check_eq("le_body_rts", 64'(rts), 64'b00100);
        check_eq("le_body_tx", 64'(txs(2)), 64'(f1));
        idle(0); step();
        check_eq("le_tail_rts", 64'(rts), 64'b00100);
        check_eq("le_tail_tx", 64'(txs(2)), 64'(f2));
        step();
        check_eq("le_done_rts", 64'(rts), 64'h0);
        check_eq("le_hold_tx", 64'(txs(2)), 64'(f2));

        // ---- N and W race for L: N first (rr from 0), no interleaving
        do_reset();
        f0 = mk(c_hdr, 2'd1, 2'd1, 12'h201);
        f1 = mk(c_body, 2'd1, 2'd1, 12'h202);
        f2 = mk(c_tail, 2'd1, 2'd1, 12'h203);
        g0 = mk(c_hdr, 2'd1, 2'd1, 12'h301);
        g1 = mk(c_body, 2'd1, 2'd1, 12'h302);
        x  = mk(c_tail, 2'd1, 2'd1, 12'h303);
        put(1, f0); put(3, g0); step();
        put(1, f1); put(3, g1); step();
        check_eq("rr_n0_rts", 64'(rts), 64'b00001);
        check_eq("rr_n0_tx", 64'(txs(0)), 64'(f0));
        put(1, f2); put(3, x); step();
        check_eq("rr_n1_tx", 64'(txs(0)), 64'(f1));
        idle(1); idle(3); step();
        check_eq("rr_n2_tx", 64'(txs(0)), 64'(f2));
        step();
        check_eq("rr_w0_rts", 64'(rts), 64'b00001);
        check_eq("rr_w0_tx", 64'(txs(0)), 64'(g0));
        step();
        check_eq("rr_w1_tx", 64'(txs(0)), 64'(g1));
        step();
        check_eq("rr_w2_tx", 64'(txs(0)), 64'(x));
        step();
        check_eq("rr_done_rts", 64'(rts), 64'h0);

        // ---- fill S (to N) while dcts[N]=0; 5th write ignored
        do_reset();
        dcts[1] = 1'b0;
        f0 = mk(c_hdr, 2'd1, 2'd0, 12'h401);
        f1 = mk(c_body, 2'd1, 2'd0, 12'h402);
        f2 = mk(c_body, 2'd1, 2'd0, 12'h403);
        f3 = mk(c_body, 2'd1, 2'd0, 12'h404);
        x  = mk(c_body, 2'd1, 2'd0, 12'h4EE);
        g0 = mk(c_tail, 2'd1, 2'd0, 12'h405);
        put(4, f0); step();
        put(4, f1); step();
        put(4, f2); step();
        check_eq("fill_cts3", 64'(cts[4]), 64'h1);
        put(4, f3); step();
        check_eq("fill_cts4", 64'(cts[4]), 64'h0);
        check_eq("fill_rts", 64'(rts), 64'h0);
        put(4, x); step();
        check_eq("fill_cts5", 64'(cts[4]), 64'h0);
        idle(4);
        dcts[1] = 1'b1; step();
        check_eq("fill_pop_cts", 64'(cts[4]), 64'h1);
        check_eq("fill_f0_rts", 64'(rts), 64'b00010);
        check_eq("fill_f0_tx", 64'(txs(1)), 64'(f0));
        put(4, g0); step();
        check_eq("fill_f1_tx", 64'(txs(1)), 64'(f1));
        idle(4); step();
        check_eq("fill_f2_tx", 64'(txs(1)), 64'(f2));
        step();
        check_eq("fill_f3_tx", 64'(txs(1)), 64'(f3));
        step();
        check_eq("fill_tail_tx", 64'(txs(1)), 64'(g0));
        check_eq("fill_tail_rts", 64'(rts), 64'b00010);
        step();
        check_eq("fill_done_rts", 64'(rts), 64'h0);

        // ---- dcts[E] low for 3 cycles mid-packet, W header waits for lock
        do_reset();
        f0 = mk(c_hdr, 2'd2, 2'd1, 12'h501);
        f1 = mk(c_body, 2'd2, 2'd1, 12'h502);
        f2 = mk(c_body, 2'd2, 2'd1, 12'h503);
        f3 = mk(c_tail, 2'd2, 2'd1, 12'h504);
        g0 = mk(c_hdr, 2'd2, 2'd1, 12'h601);
        g1 = mk(c_tail, 2'd2, 2'd1, 12'h602);
        put(0, f0); step();
        put(0, f1); step();
        check_eq("stall_h_tx", 64'(txs(2)), 64'(f0));
        put(0, f2); put(3, g0); step();
        check_eq("stall_b1_tx", 64'(txs(2)), 64'(f1));
        dcts[2] = 1'b0;
        put(0, f3); put(3, g1); step();
        check_eq("stall_c1_rts", 64'(rts), 64'h0);
        check_eq("stall_c1_tx", 64'(txs(2)), 64'(f1));
        idle(0); idle(3); step();
        check_eq("stall_c2_rts", 64'(rts), 64'h0);
        step();
        check_eq("stall_c3_rts", 64'(rts), 64'h0);
        dcts[2] = 1'b1; step();
        check_eq("stall_b2_rts", 64'(rts), 64'b00100);
        check_eq("stall_b2_tx", 64'(txs(2)), 64'(f2));
        step();
        check_eq("stall_t_tx", 64'(txs(2)), 64'(f3));
        step();
        check_eq("stall_wh_tx", 64'(txs(2)), 64'(g0));
        step();
        check_eq("stall_wt_tx", 64'(txs(2)), 64'(g1));
        step();
        check_eq("stall_done_rts", 64'(rts), 64'h0);

        // ---- masked E output: header stalls until the mask is lifted
        Cx = 4'b1101;
        f0 = mk(c_hdr, 2'd2, 2'd1, 12'h701);
        f1 = mk(c_tail, 2'd2, 2'd1, 12'h702);
        put(0, f0); step();
        put(0, f1); step();
        idle(0);
        for (int k = 0; k < 3; k++) begin
            check_eq("mask_rts", 64'(rts), 64'h0);
            step();
        end
        Cx = 4'hF; step();
        check_eq("unmask_h_tx", 64'(txs(2)), 64'(f0));
        check_eq("unmask_h_rts", 64'(rts), 64'b00100);
        step();
        check_eq("unmask_t_tx", 64'(txs(2)), 64'(f1));

        // ---- reset mid-packet, then a fresh L -> W packet
        f0 = mk(c_hdr, 2'd2, 2'd1, 12'h801);
        f1 = mk(c_body, 2'd2, 2'd1, 12'h802);
        put(0, f0); step();
        put(0, f1); step();
        put(0, f1); step();
        rst  = 1'b0;
        drts = '0;
        #1;
        check_eq("arst_rts", 64'(rts), 64'h0);
        check_eq("arst_cts", 64'(cts), 64'h1F);
        step();
        rst = 1'b1;
        step();
        g0 = mk(c_hdr, 2'd0, 2'd1, 12'h901);
        g1 = mk(c_tail, 2'd0, 2'd1, 12'h902);
        put(0, g0); step();
        put(0, g1); step();
        check_eq("post_rst_rts", 64'(rts), 64'b01000);
        check_eq("post_rst_h_tx", 64'(txs(3)), 64'(g0));
        idle(0); step();
        check_eq("post_rst_t_tx", 64'(txs(3)), 64'(g1));
        step();
        check_eq("post_rst_done", 64'(rts), 64'h0);

`ifdef NOC_PARITY_CHECK_EN
        // ---- bad parity on W: sticky perr[3], flit forwarded unchanged
        do_reset();
        f0 = mk(c_hdr, 2'd1, 2'd1, 12'hA01);
        f0[0] = ~f0[0];
        f1 = mk(c_tail, 2'd1, 2'd1, 12'hA02);
        check_eq("par_pre", 64'(perr), 64'h0);
        put(3, f0); step();
        check_eq("par_set", 64'(perr), 64'b01000);
        put(3, f1); step();
        check_eq("par_fwd_tx", 64'(txs(0)), 64'(f0));
        check_eq("par_hold1", 64'(perr), 64'b01000);
        idle(3); step();
        check_eq("par_tail_tx", 64'(txs(0)), 64'(f1));
        step();
        check_eq("par_hold2", 64'(perr), 64'b01000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
